lcd_fill_sequencer: RTL and testbench

- Hardware rectangle-fill engine for the SPI LCD path. It sits between the CPU register block and the SPI byte engine.
- On a start pulse it sequences the SPI byte engine through the full fill command stream:
  - column address set, with its arguments;
  - page address set, with its arguments;
  - memory write;
  - N pixels of one 16-bit colour.
- The CPU no longer has to push every byte by polling status.

---
 rtl/lcd_fill_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_lcd_fill_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_fill_sequencer.sv
// Rectangle-fill engine: walks the SPI byte engine through CASET/PASET/RAMWR and N pixels of one colour.
// Latency: first byte (CASET) is offered the cycle after a valid start; done pulses the cycle after the last accept.
// Backpressure: tx_valid/tx_ready handshake; the offered byte holds stable while tx_ready is low; abort drops it.
//
// Ports:
//   clk, reset_n          - clock, synchronous active-low reset
//   start, abort          - fill request (sampled in IDLE only), cancel of an in-progress fill
//   x0, x1, y0, y1, color - inclusive rectangle corners and RGB565 fill colour, latched on a valid start
//   busy, done, error     - status: not IDLE, one-cycle completion pulse, one-cycle bad-rectangle pulse
//   tx_valid/tx_ready     - byte handshake to the SPI byte engine
//   tx_data, tx_dc        - byte to send and its LCD D/C level (0 = command, 1 = data)
//   tx_last               - marks the final pixel byte so the engine can release CS
module lcd_fill_sequencer #(
  parameter int unsigned COORD_W   = 9,
  parameter logic [7:0]  CMD_CASET = 8'h2A,
  parameter logic [7:0]  CMD_PASET = 8'h2B,
  parameter logic [7:0]  CMD_RAMWR = 8'h2C
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] y1,
  input  logic [15:0]        color,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [7:0]         tx_data,
  output logic               tx_dc,
  output logic               tx_last
);

  // Two extra bits so a full-span (2^COORD_W)^2 pixel count fits without wrapping.
  localparam int unsigned CNT_W = 2 * COORD_W + 2;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD_X, S_ARG_X, S_CMD_Y, S_ARG_Y, S_CMD_W, S_PIX_HI, S_PIX_LO, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         arg_q, arg_d;
  logic [CNT_W-1:0]   pix_q, pix_d;
  logic               error_q, error_d;
  logic [COORD_W-1:0] x0_q, x1_q, y0_q, y1_q;
  logic [15:0]        color_q;

  logic               load;
  logic               accept;
  logic               rect_ok;
  logic [CNT_W-1:0]   span_x, span_y, area;
  logic [15:0]        x0_w, x1_w, y0_w, y1_w, arg_word;

  assign accept  = tx_valid && tx_ready;
  assign rect_ok = (x1 >= x0) && (y1 >= y0);
  assign span_x  = CNT_W'(x1) - CNT_W'(x0) + CNT_W'(1);
  assign span_y  = CNT_W'(y1) - CNT_W'(y0) + CNT_W'(1);
  assign area    = span_x * span_y;

  // Coordinates go out zero-extended to 16 bits, high byte first.
  assign x0_w = 16'(x0_q);
  assign x1_w = 16'(x1_q);
  assign y0_w = 16'(y0_q);
  assign y1_w = 16'(y1_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      arg_q   <= '0;
      pix_q   <= '0;
      error_q <= 1'b0;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      arg_q   <= arg_d;
      pix_q   <= pix_d;
      error_q <= error_d;
      if (load) begin
        x0_q    <= x0;
        x1_q    <= x1;
        y0_q    <= y0;
        y1_q    <= y1;
        color_q <= color;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    arg_d   = arg_q;
    pix_d   = pix_q;
    error_d = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Abort beats a simultaneous start, so a cancelled request never reports an error either.
        if (start && !abort) begin
          if (rect_ok) begin
            state_d = S_CMD_X;
            load    = 1'b1;
            pix_d   = area;
            arg_d   = 2'd0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_CMD_X: if (accept) state_d = S_ARG_X;
      S_ARG_X: if (accept) begin
        arg_d = arg_q + 2'd1;
        if (arg_q == 2'd3) state_d = S_CMD_Y;
      end
      S_CMD_Y: if (accept) state_d = S_ARG_Y;
      S_ARG_Y: if (accept) begin
        arg_d = arg_q + 2'd1;
        if (arg_q == 2'd3) state_d = S_CMD_W;
      end
      S_CMD_W:  if (accept) state_d = S_PIX_HI;
      S_PIX_HI: if (accept) state_d = S_PIX_LO;
      S_PIX_LO: if (accept) begin
        if (pix_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end else begin
          pix_d   = pix_q - CNT_W'(1);
          state_d = S_PIX_HI;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over any accept in the same cycle; the accepted byte still counts as sent.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      arg_d   = 2'd0;
    end
  end

  // Outputs depend on registered state only, so they hold stable across a stall.
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    error    = error_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_dc    = 1'b0;
    tx_last  = 1'b0;
    arg_word = 16'h0000;
    case (state_q)
      S_CMD_X: begin
        tx_valid = 1'b1;
        tx_data  = CMD_CASET;
      end
      S_ARG_X: begin
        tx_valid = 1'b1;
        tx_dc    = 1'b1;
        arg_word = arg_q[1] ? x1_w : x0_w;
        tx_data  = arg_q[0] ? arg_word[7:0] : arg_word[15:8];
      end
      S_CMD_Y: begin
        tx_valid = 1'b1;
        tx_data  = CMD_PASET;
      end
      S_ARG_Y: begin
        tx_valid = 1'b1;
        tx_dc    = 1'b1;
        arg_word = arg_q[1] ? y1_w : y0_w;
        tx_data  = arg_q[0] ? arg_word[7:0] : arg_word[15:8];
      end
      S_CMD_W: begin
        tx_valid = 1'b1;
        tx_data  = CMD_RAMWR;
      end
      S_PIX_HI: begin
        tx_valid = 1'b1;
        tx_dc    = 1'b1;
        tx_data  = color_q[15:8];
      end
      S_PIX_LO: begin
        tx_valid = 1'b1;
        tx_dc    = 1'b1;
        tx_data  = color_q[7:0];
        tx_last  = (pix_q == CNT_W'(1));
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_fill_sequencer.sv
// Directed bench for lcd_fill_sequencer: reset, stalls, back-to-back streaming, full-width row,
// invalid start, start held while busy, abort and mid-fill reset.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_lcd_fill_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, start, abort, tx_ready;
  logic [8:0] x0, x1, y0, y1;
  logic [15:0] color;
  logic       busy, done, error, tx_valid, tx_dc, tx_last;
  logic [7:0] tx_data;

  int vectors = 0;
  int miscompares = 0;

  lcd_fill_sequencer #(.COORD_W(9)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
    .busy(busy), .done(done), .error(error),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_dc(tx_dc), .tx_last(tx_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start; on return the DUT has sampled it.
  task automatic do_start(input logic [8:0] a0, input logic [8:0] a1,
                          input logic [8:0] b0, input logic [8:0] b1, input logic [15:0] c);
    x0 = a0; x1 = a1; y0 = b0; y1 = b1; color = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    vectors++;
    if ({busy, done, error, tx_valid, tx_last, tx_dc} !== 6'b0 || tx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b error=%b valid=%b last=%b dc=%b data=%h, want all 0",
               busy, done, error, tx_valid, tx_last, tx_dc, tx_data);
    end
    reset_n = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: busy=%b valid=%b, want 0 0", busy, tx_valid);
    end
  endtask

  // 1x1 at (5,7), 3-cycle stall on the third byte.
  task automatic test_stall();
    logic [7:0] eb [0:12];
    logic       ed [0:12];
    int idx, stalls, cyc;
    eb = '{8'h2A, 8'h00, 8'h05, 8'h00, 8'h05, 8'h2B, 8'h00, 8'h07, 8'h00, 8'h07, 8'h2C, 8'hF8, 8'h00};
    ed = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tx_ready = 1'b1;
    do_start(9'd5, 9'd5, 9'd7, 9'd7, 16'hF800);
    idx = 0; stalls = 0; cyc = 0;
    while (idx < 13 && cyc < 60) begin
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== eb[idx] || tx_dc !== ed[idx]) begin
        miscompares++;
        $display("FAIL stall_byte[%0d]: valid=%b data=%h dc=%b, want valid=1 data=%h dc=%b",
                 idx, tx_valid, tx_data, tx_dc, eb[idx], ed[idx]);
      end
      vectors++;
      if (tx_last !== (idx == 12) || done !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_last_done[%0d]: last=%b done=%b, want last=%b done=0",
                 idx, tx_last, done, (idx == 12));
      end
      if (idx == 2 && stalls < 3) begin
        tx_ready = 1'b0;
        stalls++;
      end else begin
        tx_ready = 1'b1;
        idx++;
      end
      tick();
      cyc++;
    end
    vectors++;
    if (idx != 13) begin
      miscompares++;
      $display("FAIL stall_count: accepted %0d bytes within budget, want 13", idx);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b1 || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_done: done=%b busy=%b valid=%b, want 1 1 0", done, busy, tx_valid);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_idle: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  // 2x3 at x=10..11, y=0..2, ready tied high: 23 bytes on 23 consecutive cycles.
  // Counting the start cycle as cycle 1, bytes occupy cycles 2..24 and done is seen in cycle 25.
  task automatic test_back_to_back();
    logic [7:0] eb [0:22];
    eb = '{8'h2A, 8'h00, 8'h0A, 8'h00, 8'h0B, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h02, 8'h2C,
           8'h12, 8'h34, 8'h12, 8'h34, 8'h12, 8'h34, 8'h12, 8'h34, 8'h12, 8'h34, 8'h12, 8'h34};
    tx_ready = 1'b1;
    do_start(9'd10, 9'd11, 9'd0, 9'd2, 16'h1234);
    for (int i = 0; i < 23; i++) begin
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== eb[i] || tx_last !== (i == 22) || done !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_byte[%0d]: valid=%b data=%h last=%b done=%b, want 1 %h %b 0",
                 i, tx_valid, tx_data, tx_last, done, eb[i], (i == 22));
      end
      tick();
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_done_cycle25: done=%b, want 1", done);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  // 480-pixel row x=0..479 at y=319.
  task automatic test_full_row();
    logic [7:0] eb [0:10];
    logic [7:0] exp_px;
    int pix_bytes, bad, last_cnt, cyc;
    eb = '{8'h2A, 8'h00, 8'h00, 8'h01, 8'hDF, 8'h2B, 8'h01, 8'h3F, 8'h01, 8'h3F, 8'h2C};
    tx_ready = 1'b1;
    do_start(9'd0, 9'd479, 9'd319, 9'd319, 16'hA55A);
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== eb[i]) begin
        miscompares++;
        $display("FAIL row_hdr[%0d]: valid=%b data=%h, want 1 %h", i, tx_valid, tx_data, eb[i]);
      end
      tick();
    end
    pix_bytes = 0; bad = 0; last_cnt = 0; cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      if (tx_valid === 1'b1) begin
        exp_px = pix_bytes[0] ? 8'h5A : 8'hA5;
        if (tx_data !== exp_px || tx_dc !== 1'b1) bad++;
        if (tx_last === 1'b1) begin
          last_cnt++;
          if (pix_bytes != 959) bad++;
        end
        pix_bytes++;
      end
      tick();
      cyc++;
    end
    vectors++;
    if (pix_bytes != 960) begin
      miscompares++;
      $display("FAIL row_pix_count: %0d pixel bytes, want 960", pix_bytes);
    end
    vectors++;
    if (bad != 0 || last_cnt != 1) begin
      miscompares++;
      $display("FAIL row_pix_content: %0d bad bytes, %0d last marks, want 0 and 1", bad, last_cnt);
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL row_done: done=%b, want 1", done);
    end
    tick();
  endtask

  // Invalid rectangles, then start held high through a whole fill.
  task automatic test_invalid();
    logic [7:0] eb [0:12];
    eb = '{8'h2A, 8'h00, 8'h05, 8'h00, 8'h05, 8'h2B, 8'h00, 8'h07, 8'h00, 8'h07, 8'h2C, 8'hF8, 8'h00};
    tx_ready = 1'b1;
    do_start(9'd20, 9'd19, 9'd0, 9'd0, 16'hFFFF);
    vectors++;
    if (error !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL inv_x_error: error=%b busy=%b valid=%b, want 1 0 0", error, busy, tx_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (error !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL inv_x_after[%0d]: error=%b busy=%b valid=%b done=%b, want 0 0 0 0",
                 i, error, busy, tx_valid, done);
      end
    end
    do_start(9'd0, 9'd0, 9'd5, 9'd4, 16'hFFFF);
    vectors++;
    if (error !== 1'b1 || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL inv_y_error: error=%b valid=%b, want 1 0", error, tx_valid);
    end
    tick();
    x0 = 9'd5; x1 = 9'd5; y0 = 9'd7; y1 = 9'd7; color = 16'hF800;
    start = 1'b1;
    tick();
    for (int i = 0; i < 13; i++) begin
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== eb[i]) begin
        miscompares++;
        $display("FAIL held_start_byte[%0d]: valid=%b data=%h, want 1 %h", i, tx_valid, tx_data, eb[i]);
      end
      tick();
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL held_start_done: done=%b, want 1", done);
    end
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL held_start_in_done_ignored: busy=%b valid=%b, want 0 0", busy, tx_valid);
    end
    tick();
  endtask

  // Abort coincident with the 5th pixel-byte accept of a 2x3 fill.
  task automatic test_abort();
    tx_ready = 1'b1;
    do_start(9'd10, 9'd11, 9'd0, 9'd2, 16'h1234);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h12) begin
          miscompares++;
          $display("FAIL abort_pre_byte: valid=%b data=%h, want 1 12", tx_valid, tx_data);
        end
        abort = 1'b1;
      end
      tick();
    end
    abort = 1'b0;
    vectors++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_next: valid=%b busy=%b done=%b, want 0 0 0", tx_valid, busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_quiet[%0d]: done=%b busy=%b, want 0 0", i, done, busy);
      end
    end
    x0 = 9'd1; x1 = 9'd2; y0 = 9'd1; y1 = 9'd2;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_start_idle: busy=%b valid=%b error=%b, want 0 0 0", busy, tx_valid, error);
    end
    do_start(9'd5, 9'd5, 9'd7, 9'd7, 16'hF800);
    vectors++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h2A || tx_dc !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_restart: valid=%b data=%h dc=%b, want 1 2a 0", tx_valid, tx_data, tx_dc);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  // Reset while the first ARG_Y byte is stalled.
  task automatic test_reset_midfill();
    tx_ready = 1'b1;
    do_start(9'd5, 9'd5, 9'd7, 9'd7, 16'hF800);
    for (int i = 0; i < 6; i++) tick();
    tx_ready = 1'b0;
    tick();
    tick();
    vectors++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h00 || tx_dc !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_stalled: valid=%b data=%h dc=%b busy=%b, want 1 00 1 1",
               tx_valid, tx_data, tx_dc, busy);
    end
    reset_n = 1'b0;
    tick();
    vectors++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_mid_drop: valid=%b busy=%b done=%b data=%h, want 0 0 0 00",
               tx_valid, busy, done, tx_data);
    end
    reset_n = 1'b1;
    tx_ready = 1'b1;
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_no_done: done=%b busy=%b, want 0 0", done, busy);
    end
    do_start(9'd5, 9'd5, 9'd7, 9'd7, 16'hF800);
    vectors++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h2A || tx_dc !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_restart: valid=%b data=%h dc=%b, want 1 2a 0", tx_valid, tx_data, tx_dc);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    tx_ready = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0;
    color = '0;
    test_reset();
    test_stall();
    test_back_to_back();
    test_full_row();
    test_invalid();
    test_abort();
    test_reset_midfill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
